// File: rtl/seven_seg_scan.sv
// Multiplexes a 4*DIGITS-bit hex value onto a common-anode 7-segment display with a dead-time gap between digits.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seven_seg_scan #(
    parameter int DIGITS     = 4,
    parameter int GAP_CYCLES = 16,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  scan_clk,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [IW-1:0]         digit_idx
);

    typedef enum logic {SHOW, GAP} state_t;

    state_t              state;
    logic [CW-1:0]       gap_cnt;
    logic                sync1, sync2, sync3, step;
    logic [4*DIGITS-1:0] snap;

    logic                wrap, gap_done, drive_show;
    logic [IW-1:0]       next_idx, disp_idx;
    logic [4*DIGITS-1:0] disp_word;
    logic [3:0]          nib;
    logic                dp_sel, blank;
    logic [DIGITS-1:0]   an_sel;
`ifdef LEADING_ZERO_BLANK_EN
    logic                upper_zero;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    // Outputs are decoded from the state the FSM is about to enter, so they
    // land on the same edge as the transition.
    always_comb begin
        wrap       = (digit_idx == IW'(DIGITS - 1));
        next_idx   = wrap ? '0 : digit_idx + 1'b1;
        gap_done   = (state == GAP) && (gap_cnt == '0);
        drive_show = ((state == SHOW) && !step) || gap_done;
        disp_idx   = gap_done ? next_idx : digit_idx;
        disp_word  = (gap_done && wrap) ? value : snap;
        nib        = '0;
        dp_sel     = 1'b0;
        an_sel     = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (disp_idx == IW'(k)) begin
                nib       = disp_word[4*k +: 4];
                dp_sel    = dp[k];
                an_sel[k] = 1'b0;
            end
        end
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (disp_word[4*k +: 4] != 4'h0)
                upper_zero = 1'b0;
            if (disp_idx == IW'(k) && upper_zero)
                blank = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= SHOW;
            gap_cnt   <= '0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            step      <= 1'b0;
            snap      <= '0;
            digit_idx <= '0;
            an_n      <= '1;
            seg_n     <= 7'b1111111;
            dp_n      <= 1'b1;
        end else begin
            sync1 <= scan_clk;
            sync2 <= sync1;
            sync3 <= sync2;
            step  <= sync2 & ~sync3;

            case (state)
                SHOW: begin
                    if (step) begin
                        state   <= GAP;
                        gap_cnt <= CW'(GAP_CYCLES - 1);
                    end
                end
                default: begin
                    if (gap_done) begin
                        state     <= SHOW;
                        digit_idx <= next_idx;
                        if (wrap)
                            snap <= value;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
            endcase

            if (drive_show && enable) begin
                an_n  <= an_sel;
                seg_n <= blank ? 7'b1111111 : hex7(nib);
                dp_n  <= ~dp_sel;
            end else begin
                an_n  <= '1;
                seg_n <= 7'b1111111;
                dp_n  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: each scan step pushes the expected next digit, popped when digit_idx moves.
module tb_seven_seg_scan;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        scan_clk = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp = 4'b0000;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [1:0]  digit_idx;

    seven_seg_scan #(.DIGITS(4), .GAP_CYCLES(16)) dut (
        .clk_in(clk_in), .rst(rst), .scan_clk(scan_clk), .enable(enable),
        .value(value), .dp(dp), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
        .digit_idx(digit_idx)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpn;
        logic [1:0] idx;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          idx_m = 0;
    logic [15:0] snap_m = 16'h0000;

    function automatic logic [6:0] hex7_m(input logic [3:0] h);
        logic [6:0] t [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[h];
    endfunction

    function automatic exp_t model_digit(input int idx, input logic [15:0] w,
                                         input logic en, input logic [3:0] dpv);
        exp_t e;
        e.idx = 2'(idx);
        if (!en) begin
            e.an  = 4'b1111;
            e.seg = 7'b1111111;
            e.dpn = 1'b1;
        end else begin
            e.an  = ~(4'b0001 << idx);
            e.seg = hex7_m(w[4*idx +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (idx > 0 && (w >> (4*idx)) == 16'h0000)
                e.seg = 7'b1111111;
`endif
            e.dpn = ~dpv[idx];
        end
        return e;
    endfunction

    task automatic advance(input bit double_edge);
        exp_t e;
        logic [1:0] start_idx;
        int c, gap_start, max_low;
        bit changed, lit;
        idx_m = (idx_m + 1) % 4;
        if (idx_m == 0) snap_m = value;
        sb_q.push_back(model_digit(idx_m, snap_m, enable, dp));
        start_idx = digit_idx;
        scan_clk = 1'b1;
        c = 0; gap_start = -1; max_low = 0; changed = 0; lit = 0;
        while (!changed && c < 40) begin
            @(negedge clk_in);
            c++;
            if ($countones(~an_n) > max_low) max_low = $countones(~an_n);
            if (an_n == 4'b1111 && gap_start < 0) gap_start = c;
            if (!enable && (an_n != 4'b1111 || seg_n != 7'b1111111 || dp_n != 1'b1)) lit = 1;
            if (digit_idx != start_idx) changed = 1;
            if (c == 2) scan_clk = 1'b0;
            if (double_edge && c == 8) scan_clk = 1'b1;
            if (double_edge && c == 10) scan_clk = 1'b0;
        end
        n_cmp++;
        if (!changed || c != 20) begin
            n_bad++;
            $display("FAIL advance_latency: digit change at cycle %0d (changed=%0d), required 20", c, changed);
        end
        if (enable) begin
            n_cmp++;
            if (gap_start != 4) begin
                n_bad++;
                $display("FAIL gap_start: anodes off from cycle %0d, required 4", gap_start);
            end
        end
        e = sb_q.pop_front();
        n_cmp++;
        if ({an_n, seg_n, dp_n, digit_idx} !== e) begin
            n_bad++;
            $display("FAIL digit_out: got an_n=%b seg_n=%b dp_n=%b idx=%0d, required an_n=%b seg_n=%b dp_n=%b idx=%0d",
                     an_n, seg_n, dp_n, digit_idx, e.an, e.seg, e.dpn, e.idx);
        end
        n_cmp++;
        if (max_low > 1) begin
            n_bad++;
            $display("FAIL one_hot: %0d anodes low, required at most 1", max_low);
        end
        if (!enable) begin
            n_cmp++;
            if (lit) begin
                n_bad++;
                $display("FAIL enable_dark: display lit while disabled, required dark");
            end
        end
        if (double_edge) begin
            repeat (12) @(negedge clk_in);
            n_cmp++;
            if (digit_idx !== e.idx || an_n === 4'b1111) begin
                n_bad++;
                $display("FAIL gap_drop: idx=%0d an_n=%b, required idx=%0d and a digit shown",
                         digit_idx, an_n, e.idx);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || dp_n !== 1'b1 || digit_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL %s: got an_n=%b seg_n=%b dp_n=%b idx=%0d, required 1111 1111111 1 0",
                     name, an_n, seg_n, dp_n, digit_idx);
        end
    endtask

    task automatic check_first_after_reset(input string name);
        exp_t e;
        idx_m  = 0;
        snap_m = 16'h0000;
        e = model_digit(0, snap_m, enable, dp);
        n_cmp++;
        if ({an_n, seg_n, dp_n, digit_idx} !== e) begin
            n_bad++;
            $display("FAIL %s: got an_n=%b seg_n=%b dp_n=%b idx=%0d, required an_n=%b seg_n=%b dp_n=%b idx=%0d",
                     name, an_n, seg_n, dp_n, digit_idx, e.an, e.seg, e.dpn, e.idx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; value = 16'h0000; dp = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check_reset_outputs("reset_hold");
            scan_clk = ~scan_clk;
        end
        scan_clk = 1'b0;
        rst = 1'b0;
        @(negedge clk_in);
        check_first_after_reset("reset_release");
    endtask

    task automatic test_scan();
        value = 16'h1234;
        repeat (8) advance(0);
    endtask

    task automatic test_snapshot();
        advance(0);
        advance(0);
        value = 16'hABCD;
        advance(0);
        advance(0);
    endtask

    task automatic test_gap_drop();
        advance(1);
    endtask

    task automatic test_enable_dp();
        enable = 1'b0;
        repeat (4) advance(0);
        enable = 1'b1;
        dp = 4'b0100;
        repeat (4) advance(0);
        dp = 4'b0000;
    endtask

    task automatic test_leading_zero();
        value = 16'h0040;
        repeat (8) advance(0);
    endtask

    task automatic test_reset_mid();
        scan_clk = 1'b1;
        repeat (10) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        check_reset_outputs("reset_mid_gap");
        scan_clk = 1'b0;
        rst = 1'b0;
        @(negedge clk_in);
        check_first_after_reset("reset_mid_release");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_gap_drop();
        test_enable_dp();
        test_leading_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
